// File: rtl/spi_reg_master.sv
// SPI master issuing two-byte register frames (command byte, data byte) to the SPI register slave.
// Start/done handshake on the host side. All outputs come from registers; spi_clk is clk_q XOR latched CPOL.
module spi_reg_master #(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [REG_W-1:0]  rdata,
  output logic [7:0]        status_o,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_BYTE0, S_GAP, S_BYTE1, S_HOLD, S_RECOVER
  } state_t;

  state_t            state_r, state_nx_s;
  logic [HC_W-1:0]   hc_r;
  logic [4:0]        ec_r, edge_num_s;
  logic              clk_q_r, cpol_r, cpha_r, rw_r;
  logic [REG_W-1:0]  wdata_r, rdata_r;
  logic [7:0]        tx_r, rx_r, status_r, cmd_s;
  logic              mosi_r, cs_n_r, busy_r, done_r;
  logic              hc_last_s, is_byte_s, half2_s;
  logic              enter_byte_s, exit_byte_s, mid_edge_s, edge_s, sample_s, shift_s;

  // Next-state decode plus per-cycle edge/sample/shift strobes.
  always_comb begin
    state_nx_s   = state_r;
    hc_last_s    = (hc_r == HC_LAST);
    is_byte_s    = (state_r == S_BYTE0) || (state_r == S_BYTE1);
    half2_s      = hc_last_s && (ec_r == 5'd1);
    enter_byte_s = 1'b0;
    exit_byte_s  = 1'b0;
    mid_edge_s   = 1'b0;
    cmd_s        = 8'(addr);
    cmd_s[7]     = rw;
    case (state_r)
      S_IDLE: begin
        if (start) state_nx_s = S_SETUP;
        else       state_nx_s = S_IDLE;
      end
      S_SETUP: begin
        if (hc_last_s) begin
          state_nx_s   = S_BYTE0;
          enter_byte_s = 1'b1;
        end else begin
          state_nx_s = S_SETUP;
        end
      end
      S_BYTE0, S_BYTE1: begin
        if (hc_last_s && (ec_r == 5'd16)) begin
          state_nx_s  = (state_r == S_BYTE0) ? S_GAP : S_HOLD;
          exit_byte_s = 1'b1;
        end else if (hc_last_s) begin
          mid_edge_s = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_GAP: begin
        if (half2_s) begin
          state_nx_s   = S_BYTE1;
          enter_byte_s = 1'b1;
        end else begin
          state_nx_s = S_GAP;
        end
      end
      S_HOLD: begin
        if (hc_last_s) state_nx_s = S_RECOVER;
        else           state_nx_s = S_HOLD;
      end
      S_RECOVER: begin
        if (half2_s) state_nx_s = S_IDLE;
        else         state_nx_s = S_RECOVER;
      end
      default: state_nx_s = S_IDLE;
    endcase
    // Edge 1 of a byte coincides with entering it; later edges start each half-period.
    edge_s     = enter_byte_s || mid_edge_s;
    edge_num_s = enter_byte_s ? 5'd1 : (ec_r + 5'd1);
    sample_s   = edge_s && (edge_num_s[0] != cpha_r);
    if (cpha_r) shift_s = mid_edge_s && edge_num_s[0];
    else        shift_s = mid_edge_s && !edge_num_s[0] && (edge_num_s != 5'd16);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstb)    state_r <= S_IDLE;
    else if (ena) state_r <= state_nx_s;
  end

  // Counters, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      hc_r     <= '0;
      ec_r     <= 5'd0;
      clk_q_r  <= 1'b0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      rw_r     <= 1'b0;
      wdata_r  <= '0;
      tx_r     <= 8'h00;
      rx_r     <= 8'h00;
      mosi_r   <= 1'b0;
      status_r <= 8'h00;
      rdata_r  <= '0;
      cs_n_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (ena) begin
      if ((state_r == S_IDLE) || hc_last_s) hc_r <= '0;
      else                                  hc_r <= hc_r + HC_W'(1);

      // In GAP/RECOVER the edge counter just marks the second half of the wait.
      if (enter_byte_s)                         ec_r <= 5'd1;
      else if (exit_byte_s || state_r == S_IDLE) ec_r <= 5'd0;
      else if (mid_edge_s)                      ec_r <= ec_r + 5'd1;
      else if ((state_r == S_GAP || state_r == S_RECOVER) && hc_last_s)
        ec_r <= (ec_r == 5'd0) ? 5'd1 : 5'd0;

      if (edge_s)          clk_q_r <= ~clk_q_r;
      else if (!is_byte_s) clk_q_r <= 1'b0;

      if (state_r == S_IDLE) begin
        cpol_r <= mode[1];
        cpha_r <= mode[0];
      end

      if (state_r == S_IDLE && start) begin
        rw_r    <= rw;
        wdata_r <= wdata;
        tx_r    <= cmd_s;
      end else if (exit_byte_s && state_r == S_BYTE0) begin
        tx_r <= rw_r ? 8'(wdata_r) : 8'h00;
      end else if (shift_s) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end

      if (enter_byte_s)                    mosi_r <= tx_r[7];
      else if (shift_s)                    mosi_r <= tx_r[6];
      else if (!is_byte_s || exit_byte_s)  mosi_r <= 1'b0;

      if (sample_s) rx_r <= {rx_r[6:0], spi_miso};
      if (exit_byte_s && state_r == S_BYTE0) status_r <= rx_r;
      if (exit_byte_s && state_r == S_BYTE1 && !rw_r) rdata_r <= rx_r;

      cs_n_r <= (state_nx_s == S_IDLE) || (state_nx_s == S_RECOVER);
      busy_r <= (state_nx_s != S_IDLE);
      done_r <= (state_r == S_HOLD) && (state_nx_s == S_RECOVER);
    end
  end

  assign spi_clk  = clk_q_r ^ cpol_r;
  assign spi_mosi = mosi_r;
  assign spi_cs_n = cs_n_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign rdata    = rdata_r;
  assign status_o = status_r;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a behavioural SPI register slave on the bus, a table of
// directed frames, and hand sequences for back-to-back starts, ena gating and mid-frame reset.
module tb_spi_reg_master;

  logic       clk = 1'b0;
  logic       rstb, ena, start, rw;
  logic [1:0] mode;
  logic [2:0] addr;
  logic [7:0] wdata, rdata, status_o;
  logic       busy, done, spi_clk, spi_mosi, spi_miso, spi_cs_n;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .status_o(status_o), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  // Slave model: detects spi_clk edges while selected, samples/drives per mode.
  logic [7:0] sreg [0:7];
  logic [7:0] s_status, s_tx, s_rx, s_cmd, s_dat;
  logic       s_prev_clk;
  int         s_e, s_byte, s_dv;
  initial s_dv = 0;

  always @(negedge clk) begin : slave_model
    int idx;
    if (spi_cs_n) begin
      s_e = 0; s_byte = 0; s_tx = s_status; spi_miso = s_status[7];
    end else begin
      if (spi_clk != s_prev_clk) begin
        s_e = s_e + 1;
        if ((mode[0] && (s_e % 2 == 0)) || (!mode[0] && (s_e % 2 == 1)))
          s_rx = {s_rx[6:0], spi_mosi};
        if (s_e == 16) begin
          if (s_byte == 0) begin
            s_cmd = s_rx;
            s_tx  = s_cmd[7] ? 8'h00 : sreg[s_cmd[2:0]];
          end else begin
            s_dat = s_rx;
            if (s_cmd[7]) begin
              sreg[s_cmd[2:0]] = s_rx;
              s_dv = s_dv + 1;
            end
          end
          s_byte = s_byte + 1;
          s_e = 0;
        end
      end
      if (mode[0]) idx = (s_e == 0) ? 0 : (s_e - 1) / 2;
      else         idx = (s_e / 2 > 7) ? 7 : s_e / 2;
      spi_miso = s_tx[7 - idx];
    end
    s_prev_clk = spi_clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (busy) begin
      err_cnt++;
      $display("FAIL wait_idle: busy still high after %0d cycles", n);
    end
  endtask

  typedef struct {
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [1:0] mode;
    logic [7:0] status;
    int         ena_at;
    logic [7:0] exp_cmd;
    logic [7:0] exp_dat;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];
  vec_t post;

  task automatic run_frame(input vec_t v);
    int cyc, done_cyc, done_cnt, dv0, ext;
    logic [20:0] snap;
    logic frz_bad, cpol;
    logic [7:0] rd_d, st_d;
    ext = (v.ena_at != 0) ? 20 : 0;
    cpol = v.mode[1];
    wait_idle();
    @(negedge clk);
    mode = v.mode; rw = v.rw; addr = v.addr; wdata = v.wdata; s_status = v.status;
    repeat (2) @(negedge clk);
    check("clk_idle_pre", spi_clk, cpol);
    dv0 = s_dv;
    start = 1'b1;
    @(posedge clk);
    cyc = 1; done_cyc = 0; done_cnt = 0; frz_bad = 1'b0; snap = '0;
    rd_d = 8'h00; st_d = 8'h00;
    while (cyc <= 153 + ext) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check("cs_fall_c1", spi_cs_n, 1'b0);
        check("busy_c1", busy, 1'b1);
      end
      if (cyc == 4) begin
        check("clk_setup", spi_clk, cpol);
        check("mosi_setup", spi_mosi, 1'b0);
      end
      if (cyc == 5) begin
        check("clk_edge1", spi_clk, !cpol);
        check("mosi_msb", spi_mosi, v.exp_cmd[7]);
      end
      if (cyc == 72) begin
        check("clk_gap", spi_clk, cpol);
        check("cs_gap", spi_cs_n, 1'b0);
        check("mosi_gap", spi_mosi, 1'b0);
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; rd_d = rdata; st_d = status_o;
      end
      if (v.ena_at != 0) begin
        if (cyc == v.ena_at) begin
          snap = {spi_cs_n, spi_clk, spi_mosi, busy, done, rdata, status_o};
          ena = 1'b0;
        end else if (cyc > v.ena_at && cyc <= v.ena_at + 20) begin
          if (snap != {spi_cs_n, spi_clk, spi_mosi, busy, done, rdata, status_o}) frz_bad = 1'b1;
          if (cyc == v.ena_at + 20) ena = 1'b1;
        end
      end
      if (cyc == 152 + ext) check("busy_last", busy, 1'b1);
      if (cyc == 153 + ext) begin
        check("busy_drop", busy, 1'b0);
        check("cs_idle", spi_cs_n, 1'b1);
        check("clk_idle_post", spi_clk, cpol);
      end
      @(posedge clk);
      cyc++;
    end
    check("done_cycle", done_cyc, 145 + ext);
    check("done_pulses", done_cnt, 1);
    check("rdata", rd_d, v.exp_rdata);
    check("status", st_d, v.status);
    check("mosi_cmd", s_cmd, v.exp_cmd);
    check("mosi_data", s_dat, v.exp_dat);
    check("slave_dv", s_dv - dv0, v.rw ? 1 : 0);
    if (v.rw) check("slave_reg", sreg[v.addr], v.wdata);
    if (v.ena_at != 0) check("ena_freeze", frz_bad, 1'b0);
  endtask

  initial begin
    int cyc, dcnt, fall2, hi, himax, dv0;
    logic prev_cs, qbad;
    sreg[0] = 8'h00; sreg[1] = 8'h81; sreg[2] = 8'h27; sreg[3] = 8'h3C;
    sreg[4] = 8'h4E; sreg[5] = 8'h00; sreg[6] = 8'h69; sreg[7] = 8'h7B;
    s_status = 8'h00;
    //               rw    addr  wdata  mode  status ena  cmd    data   rdata
    vecs[0]  = '{1'b1, 3'd5, 8'hA5, 2'd0, 8'h5A, 0,   8'h85, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 3'd3, 8'h00, 2'd0, 8'h5A, 0,   8'h03, 8'h00, 8'h3C};
    vecs[2]  = '{1'b0, 3'd4, 8'h00, 2'd1, 8'h11, 0,   8'h04, 8'h00, 8'h4E};
    vecs[3]  = '{1'b1, 3'd4, 8'hC3, 2'd1, 8'h12, 0,   8'h84, 8'hC3, 8'h4E};
    vecs[4]  = '{1'b0, 3'd4, 8'h00, 2'd1, 8'h13, 0,   8'h04, 8'h00, 8'hC3};
    vecs[5]  = '{1'b0, 3'd6, 8'h00, 2'd2, 8'h21, 0,   8'h06, 8'h00, 8'h69};
    vecs[6]  = '{1'b1, 3'd6, 8'hC3, 2'd2, 8'h22, 0,   8'h86, 8'hC3, 8'h69};
    vecs[7]  = '{1'b0, 3'd6, 8'h00, 2'd2, 8'h23, 0,   8'h06, 8'h00, 8'hC3};
    vecs[8]  = '{1'b0, 3'd7, 8'h00, 2'd3, 8'h31, 0,   8'h07, 8'h00, 8'h7B};
    vecs[9]  = '{1'b1, 3'd7, 8'hC3, 2'd3, 8'h32, 0,   8'h87, 8'hC3, 8'h7B};
    vecs[10] = '{1'b0, 3'd7, 8'h00, 2'd3, 8'h33, 0,   8'h07, 8'h00, 8'hC3};
    vecs[11] = '{1'b0, 3'd1, 8'h00, 2'd0, 8'hA5, 100, 8'h01, 8'h00, 8'h81};
    vecs[12] = '{1'b0, 3'd5, 8'h00, 2'd0, 8'h0F, 0,   8'h05, 8'h00, 8'hA5};
    post     = '{1'b0, 3'd2, 8'h00, 2'd0, 8'h3E, 0,   8'h02, 8'h00, 8'h27};

    rstb = 1'b0; ena = 1'b1; start = 1'b0; rw = 1'b0; mode = 2'd0; addr = 3'd0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1'b1);
    check("rst_clk", spi_clk, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_status", status_o, 8'h00);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) run_frame(vecs[i]);

    // Back-to-back with start held high: second request during busy is ignored.
    wait_idle();
    @(negedge clk);
    mode = 2'd0; rw = 1'b1; addr = 3'd6; wdata = 8'h5C; s_status = 8'h77;
    repeat (2) @(negedge clk);
    dv0 = s_dv;
    start = 1'b1;
    @(posedge clk);
    cyc = 1; dcnt = 0; fall2 = 0; hi = 0; himax = 0; prev_cs = 1'b0;
    while (cyc <= 304) begin
      @(negedge clk);
      if (done) dcnt++;
      if (spi_cs_n) hi++;
      else begin
        if (hi > himax) himax = hi;
        hi = 0;
      end
      if (prev_cs && !spi_cs_n && fall2 == 0) fall2 = cyc;
      prev_cs = spi_cs_n;
      if (cyc == 304) start = 1'b0;
      @(posedge clk);
      cyc++;
    end
    check("b2b_done_cnt", dcnt, 2);
    check("b2b_second_cs_fall", fall2, 154);
    check("b2b_cs_high_gap", himax, 9);
    check("b2b_slave_dv", s_dv - dv0, 2);
    check("b2b_slave_reg", sreg[6], 8'h5C);
    qbad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (!spi_cs_n) qbad = 1'b1;
    end
    check("no_queued_frame", qbad, 1'b0);

    // Reset asserted on BYTE0 edge 7 (cycle 29).
    wait_idle();
    @(negedge clk);
    mode = 2'd0; rw = 1'b0; addr = 3'd4; s_status = 8'hE7;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    while (cyc < 29) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("edge7_clk", spi_clk, 1'b1);
    rstb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs_n", spi_cs_n, 1'b1);
    check("midrst_clk", spi_clk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_mosi", spi_mosi, 1'b0);
    check("midrst_rdata", rdata, 8'h00);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(post);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
